// File: rtl/counter_16bits.sv
// 16-bit synchronous up-counter with a synchronous active-high clear.
// The datapath is four cascaded 4-bit slices. Each slice is built from
// toggle stages, and the slices are joined by an enable/terminal-count
// carry chain. Every flop runs on Clk; there is no ripple clocking.

// Single toggle storage stage with a synchronous clear.
module cnt16_tstage (
  input  logic clk,
  input  logic clr,
  input  logic t,
  output logic q
);

  // Clear has priority over toggle. Both take effect only on the rising edge.
  always_ff @(posedge clk) begin
    if (clr)
      q <= 1'b0;
    else if (t)
      q <= ~q;
  end

endmodule

// 4-bit counting slice. Stage i toggles when en is high and all lower stages are 1.
module cnt16_slice4 (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       tc
);

  logic [3:0] t;

  // Per-stage toggle enables: the carry inside the slice.
  always_comb begin
    t[0] = en;
    t[1] = en & q[0];
    t[2] = en & q[0] & q[1];
    t[3] = en & q[0] & q[1] & q[2];
  end

  // Terminal count means the slice is at all ones. The next enabled edge carries out.
  assign tc = &q;

  cnt16_tstage u_stage0 (.clk(clk), .clr(clr), .t(t[0]), .q(q[0]));
  cnt16_tstage u_stage1 (.clk(clk), .clr(clr), .t(t[1]), .q(q[1]));
  cnt16_tstage u_stage2 (.clk(clk), .clr(clr), .t(t[2]), .q(q[2]));
  cnt16_tstage u_stage3 (.clk(clk), .clr(clr), .t(t[3]), .q(q[3]));

endmodule

// Top level. Port order is fixed so the counter can be instantiated positionally.
module counter_16bits (
  output logic [15:0] COUNT,
  input  logic        Clr,
  input  logic        Clk
);

  logic [4:0] en;
  logic [3:0] tc;

  // Slice 0 is always enabled. Each later slice is enabled only when every lower slice is at terminal count.
  always_comb begin
    en[0] = 1'b1;
    en[1] = en[0] & tc[0];
    en[2] = en[1] & tc[1];
    en[3] = en[2] & tc[2];
    en[4] = en[3] & tc[3];
  end

  cnt16_slice4 u_slice0 (.clk(Clk), .clr(Clr), .en(en[0]), .q(COUNT[3:0]),   .tc(tc[0]));
  cnt16_slice4 u_slice1 (.clk(Clk), .clr(Clr), .en(en[1]), .q(COUNT[7:4]),   .tc(tc[1]));
  cnt16_slice4 u_slice2 (.clk(Clk), .clr(Clr), .en(en[2]), .q(COUNT[11:8]),  .tc(tc[2]));
  cnt16_slice4 u_slice3 (.clk(Clk), .clr(Clr), .en(en[3]), .q(COUNT[15:12]), .tc(tc[3]));

  // en[4] is the carry out of the whole counter. Wrap-around produces no flag, so it is left unused.
  logic unused_carry;
  assign unused_carry = en[4];

endmodule

// File: tb/tb_counter_16bits.sv
// Directed testbench for counter_16bits. Inputs change 1 ns after each rising
// edge, and outputs are sampled at that same point.
module tb_counter_16bits;

  logic [15:0] COUNT;
  logic        Clr;
  logic        Clk;

  int checks = 0;
  int errors = 0;

  counter_16bits dut (.COUNT(COUNT), .Clr(Clr), .Clk(Clk));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] exp);
    checks++;
    if (COUNT !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, COUNT, exp);
    end
  endtask

  // Two clear edges, then ten counting edges.
  task automatic test_reset();
    Clr = 1'b1;
    tick(); check("reset_edge1", 16'h0000);
    tick(); check("reset_edge2", 16'h0000);
    Clr = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick(); check("count_after_reset", 16'(i));
    end
  endtask

  // Count to 5, then apply one clear pulse.
  task automatic test_pulse_clr();
    Clr = 1'b1; tick(); check("pulse_pre_clr", 16'h0000);
    Clr = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(); check("pulse_count", 16'(i));
    end
    Clr = 1'b1; tick(); check("pulse_clr", 16'h0000);
    Clr = 1'b0; tick(); check("pulse_after", 16'h0001);
  endtask

  // Glitch Clr between edges; COUNT must not react, and the next edge still increments.
  task automatic test_async_clr();
    Clr = 1'b1; tick(); Clr = 1'b0;
    for (int i = 1; i <= 3; i++) tick();
    check("between_pre", 16'h0003);
    Clr = 1'b1; #2; check("between_clr_high", 16'h0003);
    Clr = 1'b0; #1; check("between_clr_low", 16'h0003);
    tick(); check("between_next_edge", 16'h0004);
  endtask

  // Carries across slices, with an explicit check at each slice boundary.
  task automatic test_carry();
    logic [15:0] exp;
    Clr = 1'b1; tick(); Clr = 1'b0;
    exp = 16'h0000;
    while (exp != 16'h1000) begin
      exp = exp + 16'h1;
      tick();
      if (exp == 16'h0010) check("carry_000f_0010", 16'h0010);
      else if (exp == 16'h0100) check("carry_00ff_0100", 16'h0100);
      else if (exp == 16'h1000) check("carry_0fff_1000", 16'h1000);
      else if (exp == 16'h000f || exp == 16'h00ff || exp == 16'h0fff) check("carry_pre", exp);
    end
  endtask

  // Full cycle: every step is +1, and FFFF wraps to 0000.
  task automatic test_wrap();
    logic [15:0] exp;
    logic        saw_ffff;
    int          step_err;
    Clr = 1'b1; tick(); Clr = 1'b0;
    exp = 16'h0000;
    saw_ffff = 1'b0;
    step_err = 0;
    for (int i = 0; i < 65536; i++) begin
      tick();
      exp = exp + 16'h1;
      if (COUNT === 16'hffff) saw_ffff = 1'b1;
      if (COUNT !== exp) begin
        step_err++;
        if (step_err <= 8) $display("FAIL wrap_step: got %h expected %h", COUNT, exp);
      end
    end
    checks++;
    if (step_err != 0) begin
      errors++;
      $display("FAIL wrap_steps: got %0d bad steps expected 0", step_err);
    end
    checks++;
    if (saw_ffff !== 1'b1) begin
      errors++;
      $display("FAIL wrap_saw_ffff: got %b expected 1", saw_ffff);
    end
    check("wrap_final", 16'h0000);
  endtask

  // Count to 1234, then hold clear for 20 edges.
  task automatic test_hold_clr();
    Clr = 1'b1; tick(); Clr = 1'b0;
    for (int i = 0; i < 16'h1234; i++) tick();
    check("hold_reach_1234", 16'h1234);
    Clr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(); check("hold_clr", 16'h0000);
    end
    Clr = 1'b0; tick(); check("hold_release", 16'h0001);
  endtask

  initial begin
    Clr = 1'b1;
    #1;
    test_reset();
    test_pulse_clr();
    test_async_clr();
    test_carry();
    test_hold_clr();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_16bits.md
COUNTER_16BITS -- requirements
Module: counter_16bits

Interface
- Parameters: none; width fixed at 16 bits.
- REQ-001: Ports SHALL be declared in the positional order COUNT, Clr, Clk, to allow positional instantiation.
- REQ-002: Clk  input  1  sole clock; all state updates on the rising edge.
- REQ-003: Clr  input  1  reset, synchronous, active-high; sampled only on the rising edge of Clk.
- REQ-004: COUNT  output  16  current count value, unsigned, registered; bit 15 is the MSB.

Function
- REQ-005: On each rising Clk edge with Clr=1, COUNT SHALL become 16'h0000.
- REQ-006: On each rising Clk edge with Clr=0, COUNT SHALL become (COUNT + 1) mod 2^16.
- REQ-007: Wrap-around: COUNT=16'hFFFF with Clr=0 SHALL produce 16'h0000 on the next edge. No flag or stall occurs at wrap.
- REQ-008: Clr SHALL take priority over increment when both apply on the same edge.
- REQ-009: Latency SHALL be one cycle: a Clr or increment decision sampled at edge n is visible on COUNT immediately after edge n.
- REQ-010: COUNT SHALL change only at rising Clk edges. It SHALL hold between edges and SHALL NOT respond combinationally to Clr.
- REQ-011: The datapath SHALL be built as four cascaded 4-bit slices (bits 3:0, 7:4, 11:8, 15:12).
- REQ-012: Each slice SHALL be built from four toggle-type storage stages with a synchronous clear.
- REQ-013: Within a slice, stage i SHALL toggle when the slice enable is 1 and all lower stages of that slice are 1.
- REQ-014: Slice 0 enable SHALL be constant 1 (when Clr=0).
- REQ-015: The enable of slice k+1 SHALL be the enable of slice k AND'ed with the terminal-count (all ones) of slice k. This forms a synchronous carry chain with no ripple clocking.
- REQ-016: All stages SHALL share Clk. No derived or gated clocks are allowed.
- REQ-017: Submodule names SHALL be distinct from counter_16bits and from any test module name.
- REQ-018: Before the first edge with Clr=1, COUNT is unspecified (X permitted in simulation). Users SHALL apply Clr before relying on COUNT.

Reset
- REQ-019: The reset value of COUNT SHALL be 16'h0000.
- REQ-020: Reset SHALL be fully synchronous: Clr asserted between edges has no effect until the next rising edge.
- REQ-021: While Clr is held at 1, COUNT SHALL remain 16'h0000 on every edge.
- REQ-022: After reset, the first edge with Clr=0 SHALL produce COUNT=16'h0001.
- REQ-023: Reset mid-count SHALL override any increment on that edge and return COUNT to 16'h0000.

Verification
- REQ-024: Clr=1 for 2 edges, then Clr=0 for 10 edges -> COUNT reads 0,0 then 1,2,...,10 after successive edges.
- REQ-025: Count to 16'h0005, pulse Clr=1 for exactly one edge -> COUNT=16'h0000 after that edge, then 16'h0001 on the next edge.
- REQ-026: Toggle Clr between edges without a rising edge occurring -> COUNT unchanged.
- REQ-027: Slice carry propagation -> transitions 16'h000F->0010, 16'h00FF->0100 and 16'h0FFF->1000, each in exactly one edge.
- REQ-028: Run 65536 edges from 16'h0000 with Clr=0 -> COUNT passes 16'hFFFF then returns to 16'h0000, with each step exactly +1.
- REQ-029: Hold Clr=1 for 20 edges after counting to 16'h1234 -> COUNT is 16'h0000 on all 20 edges.
